decode_stage: RTL and testbench

Parametrised, multi-lane decode stage between fetch and rename. It buffers fetched instruction words in a circular queue and decodes up to `WIDTH` instructions per cycle into micro-op bundles. Each bundle carries the decode control word, branch control, register specifiers, packed immediate and PC. Shadow state for short-forward branches is carried across cycles, so shadow marking is correct across fetch-packet boundaries.

---
 rtl/decode_stage_pkg.sv | 72 +++++++
 rtl/decode_stage_lane.sv | 139 +++++++++++++
 rtl/decode_stage.sv | 116 +++++++++++
 tb/tb_decode_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode types: control words, branch control, micro-op bundle and immediate helpers.
// Pure type/function package, no timing or flow control of its own.
package rv32i_types;

    localparam int SFO_CNT_W = 4;

    typedef enum logic [4:0] {
        UOP_NOP, UOP_ADD, UOP_SUB, UOP_SLL, UOP_SLT, UOP_SLTU, UOP_XOR, UOP_SRL,
        UOP_SRA, UOP_OR, UOP_AND, UOP_LUI, UOP_AUIPC, UOP_JAL, UOP_JALR, UOP_BR,
        UOP_LD, UOP_ST, UOP_FENCE, UOP_ECALL, UOP_EBREAK
    } uopc_e;

    typedef enum logic [1:0] {EXU_ALU, EXU_BRU, EXU_LSU, EXU_SYS} exut_e;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} immt_e;

    typedef struct packed {
        logic       legal;
        uopc_e      uopc;
        exut_e      exut;
        immt_e      immt;
        logic [2:0] fn3;
        logic       rd_wen;
        logic       rs1_ren;
        logic       rs2_ren;
    } ctrl_t;

    typedef struct packed {
        logic is_br;
        logic is_jal;
        logic is_jalr;
        logic shadowable;
        logic sfb;
    } bctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        bctrl_t      bctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] packed_imm;
        logic [31:0] pc;
        logic        shadowed;
        logic        sfo_cancel;
    } decoded_uop_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] ins, input immt_e t);
        case (t)
            IMM_I:   gen_imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   gen_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   gen_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   gen_imm = {ins[31:12], 12'b0};
            IMM_J:   gen_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: gen_imm = '0;
        endcase
    endfunction

    function automatic uopc_e alu_uopc(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_uopc = alt ? UOP_SUB : UOP_ADD;
            3'd1:    alu_uopc = UOP_SLL;
            3'd2:    alu_uopc = UOP_SLT;
            3'd3:    alu_uopc = UOP_SLTU;
            3'd4:    alu_uopc = UOP_XOR;
            3'd5:    alu_uopc = alt ? UOP_SRA : UOP_SRL;
            3'd6:    alu_uopc = UOP_OR;
            default: alu_uopc = UOP_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_lane.sv
// decode_lane: combinational single-instruction decoder with chained short-forward-branch shadow count.
// Zero latency, no flow control; shadow ports exist only when DECODE_SFO_EN is defined.
module decode_lane
    import rv32i_types::*;
#(
    parameter int SHADOW_MAX = 4
) (
    input  logic [31:0]          instr_i,
    input  logic [31:0]          pc_i,
`ifdef DECODE_SFO_EN
    input  logic [SFO_CNT_W-1:0] shadow_cnt_i,
    output logic [SFO_CNT_W-1:0] shadow_cnt_o,
`endif
    output decoded_uop_t         uop_o
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    ctrl_t       ctrl;
    bctrl_t      bctrl;
    logic [31:0] imm;
    logic [29:0] len_words;
    logic        sfb;
    logic        shadowed;
    logic        cancel;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    always_comb begin
        ctrl     = '0;
        bctrl    = '0;
        ctrl.fn3 = f3;
        case (opcode)
            7'b0110111: begin
                ctrl.legal = 1'b1; ctrl.uopc = UOP_LUI; ctrl.exut = EXU_ALU;
                ctrl.immt = IMM_U; ctrl.rd_wen = 1'b1;
            end
            7'b0010111: begin
                ctrl.legal = 1'b1; ctrl.uopc = UOP_AUIPC; ctrl.exut = EXU_ALU;
                ctrl.immt = IMM_U; ctrl.rd_wen = 1'b1;
            end
            7'b1101111: begin
                ctrl.legal = 1'b1; ctrl.uopc = UOP_JAL; ctrl.exut = EXU_BRU;
                ctrl.immt = IMM_J; ctrl.rd_wen = 1'b1; bctrl.is_jal = 1'b1;
            end
            7'b1100111: begin
                ctrl.legal = (f3 == 3'd0); ctrl.uopc = UOP_JALR; ctrl.exut = EXU_BRU;
                ctrl.immt = IMM_I; ctrl.rd_wen = 1'b1; ctrl.rs1_ren = 1'b1;
                bctrl.is_jalr = (f3 == 3'd0);
            end
            7'b1100011: begin
                ctrl.legal = (f3 != 3'd2) && (f3 != 3'd3); ctrl.uopc = UOP_BR;
                ctrl.exut = EXU_BRU; ctrl.immt = IMM_B;
                ctrl.rs1_ren = 1'b1; ctrl.rs2_ren = 1'b1;
                bctrl.is_br = (f3 != 3'd2) && (f3 != 3'd3);
            end
            7'b0000011: begin
                ctrl.legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                ctrl.uopc = UOP_LD; ctrl.exut = EXU_LSU; ctrl.immt = IMM_I;
                ctrl.rd_wen = 1'b1; ctrl.rs1_ren = 1'b1;
            end
            7'b0100011: begin
                ctrl.legal = (f3 <= 3'd2); ctrl.uopc = UOP_ST; ctrl.exut = EXU_LSU;
                ctrl.immt = IMM_S; ctrl.rs1_ren = 1'b1; ctrl.rs2_ren = 1'b1;
            end
            7'b0010011: begin
                ctrl.legal = !((f3 == 3'd1) && (f7 != 7'd0)) &&
                             !((f3 == 3'd5) && (f7 != 7'd0) && (f7 != 7'b0100000));
                ctrl.uopc = alu_uopc(f3, (f3 == 3'd5) && f7[5]);
                ctrl.exut = EXU_ALU; ctrl.immt = IMM_I;
                ctrl.rd_wen = 1'b1; ctrl.rs1_ren = 1'b1;
            end
            7'b0110011: begin
                ctrl.legal = (f7 == 7'd0) ||
                             ((f7 == 7'b0100000) && ((f3 == 3'd0) || (f3 == 3'd5)));
                ctrl.uopc = alu_uopc(f3, f7[5]);
                ctrl.exut = EXU_ALU;
                ctrl.rd_wen = 1'b1; ctrl.rs1_ren = 1'b1; ctrl.rs2_ren = 1'b1;
            end
            7'b0001111: begin
                ctrl.legal = 1'b1; ctrl.uopc = UOP_FENCE; ctrl.exut = EXU_SYS;
            end
            7'b1110011: begin
                ctrl.legal = (instr_i == 32'h0000_0073) || (instr_i == 32'h0010_0073);
                ctrl.uopc  = instr_i[20] ? UOP_EBREAK : UOP_ECALL;
                ctrl.exut  = EXU_SYS;
            end
            default: ;
        endcase
        bctrl.shadowable = ctrl.legal && (ctrl.exut == EXU_ALU);
    end

    assign imm       = gen_imm(instr_i, ctrl.immt);
    assign len_words = imm[31:2] - 30'd1;
    // Short forward branch: positive offset of at least one word, shadow fits in SHADOW_MAX.
    assign sfb       = bctrl.is_br && !imm[31] && (imm[31:2] != 30'd0) &&
                       (len_words <= 30'(SHADOW_MAX));

`ifdef DECODE_SFO_EN
    always_comb begin
        shadowed     = 1'b0;
        cancel       = 1'b0;
        shadow_cnt_o = shadow_cnt_i;
        if (sfb) begin
            cancel       = (shadow_cnt_i != '0);
            shadow_cnt_o = len_words[SFO_CNT_W-1:0];
        end else if (shadow_cnt_i != '0) begin
            if (bctrl.shadowable) begin
                shadowed     = 1'b1;
                shadow_cnt_o = shadow_cnt_i - 1'b1;
            end else begin
                cancel       = 1'b1;
                shadow_cnt_o = '0;
            end
        end
    end
`else
    assign shadowed = 1'b0;
    assign cancel   = 1'b0;
`endif

    always_comb begin
        uop_o            = '0;
        uop_o.ctrl       = ctrl;
        uop_o.bctrl      = bctrl;
        uop_o.bctrl.sfb  = sfb;
        uop_o.rd         = instr_i[11:7];
        uop_o.rs1        = instr_i[19:15];
        uop_o.rs2        = instr_i[24:20];
        uop_o.packed_imm = imm;
        uop_o.pc         = pc_i;
        uop_o.shadowed   = shadowed;
        uop_o.sfo_cancel = cancel;
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: circular fetch queue feeding WIDTH chained decode lanes; push visible next cycle, no bypass.
// fetch_ready = WIDTH free entries (registered only); dec_ready pops all valid lanes; DECODE_SFO_EN adds shadow tracking.
module decode_stage
    import rv32i_types::*;
#(
    parameter int WIDTH      = 2,
    parameter int DEPTH      = 8,
    parameter int SHADOW_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         fetch_valid,
    input  logic [$clog2(WIDTH+1)-1:0]   fetch_count,
    input  logic [32*WIDTH-1:0]          fetch_instr,
    input  logic [31:0]                  fetch_pc,
    output logic                         fetch_ready,
    output logic [WIDTH-1:0]             dec_valid,
    output decoded_uop_t [WIDTH-1:0]     dec_uop,
    input  logic                         dec_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             push, pop;
    logic [CNT_W-1:0] push_n, pop_n;

    assign fetch_ready = (OCC_W'(DEPTH) - occ_q) >= OCC_W'(WIDTH);
    assign push        = fetch_valid && fetch_ready && !flush;
    assign pop         = dec_ready && dec_valid[0];

    always_comb begin
        dec_valid = '0;
        for (int i = 0; i < WIDTH; i++) dec_valid[i] = (occ_q > OCC_W'(i));
    end

    always_comb begin
        pop_n  = '0;
        push_n = push ? fetch_count : '0;
        if (pop) pop_n = (occ_q >= OCC_W'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(occ_q);
        head_d = head_q + PTR_W'(pop_n);
        tail_d = tail_q + PTR_W'(push_n);
        occ_d  = occ_q + OCC_W'(push_n) - OCC_W'(pop_n);
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Payload storage needs no reset: only entries below occupancy are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (CNT_W'(i) < fetch_count) begin
                    instr_mem[tail_q + PTR_W'(i)] <= fetch_instr[32*i +: 32];
                    pc_mem[tail_q + PTR_W'(i)]    <= fetch_pc + 32'(4 * i);
                end
            end
        end
    end

`ifdef DECODE_SFO_EN
    logic [SFO_CNT_W-1:0] shadow_cnt_q, shadow_cnt_d;
    logic [SFO_CNT_W-1:0] cnt_chain [WIDTH+1];

    assign cnt_chain[0] = shadow_cnt_q;

    always_comb begin
        shadow_cnt_d = shadow_cnt_q;
        if (flush)    shadow_cnt_d = '0;
        else if (pop) shadow_cnt_d = cnt_chain[pop_n];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow_cnt_q <= '0;
        else     shadow_cnt_q <= shadow_cnt_d;
    end
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        logic [PTR_W-1:0] idx;
        assign idx = head_q + PTR_W'(g);

        decode_lane #(
            .SHADOW_MAX   (SHADOW_MAX)
        ) u_lane (
            .instr_i      (instr_mem[idx]),
            .pc_i         (pc_mem[idx]),
`ifdef DECODE_SFO_EN
            .shadow_cnt_i (cnt_chain[g]),
            .shadow_cnt_o (cnt_chain[g+1]),
`endif
            .uop_o        (dec_uop[g])
        );
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (WIDTH=2, DEPTH=8): queue order/wrap, backpressure, flush, shadows, reset.
module tb_decode_stage;
    import rv32i_types::*;

    localparam int WIDTH = 2;
    localparam int DEPTH = 8;
`ifdef DECODE_SFO_EN
    localparam bit SFO_ON = 1'b1;
`else
    localparam bit SFO_ON = 1'b0;
`endif

    localparam logic [31:0] ADDI5 = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] ADDI7 = 32'h0070_0113;  // addi x2,x0,7
    localparam logic [31:0] ADD   = 32'h0020_81B3;  // add  x3,x1,x2
    localparam logic [31:0] XOR   = 32'h0020_C233;  // xor  x4,x1,x2
    localparam logic [31:0] BEQ12 = 32'h0020_8663;  // beq  x1,x2,+12
    localparam logic [31:0] BNE16 = 32'h0020_9863;  // bne  x1,x2,+16
    localparam logic [31:0] LW    = 32'h0000_A283;  // lw   x5,0(x1)

    logic              clk = 1'b0;
    logic              rst, flush, fetch_valid, fetch_ready, dec_ready;
    logic [1:0]        fetch_count;
    logic [63:0]       fetch_instr;
    logic [31:0]       fetch_pc;
    logic [1:0]        dec_valid;
    decoded_uop_t [1:0] dec_uop;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];

    always #5 clk = ~clk;

    decode_stage #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .SHADOW_MAX  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_count (fetch_count),
        .fetch_instr (fetch_instr),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .dec_valid   (dec_valid),
        .dec_uop     (dec_uop),
        .dec_ready   (dec_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int id);
        return 32'h13 | (32'(id) << 7) | (32'(id) << 20);
    endfunction

    // One clock: drive inputs, check outputs against the queue model mid-cycle, then advance the model.
    task automatic cycle(input bit fv, input int cnt, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] pc, input bit dr, input bit fl);
        int          sz, nv;
        bit          rdy;
        logic [31:0] w;
        fetch_valid = fv;
        fetch_count = 2'(cnt);
        fetch_instr = {w1, w0};
        fetch_pc    = pc;
        dec_ready   = dr;
        flush       = fl;
        @(negedge clk);
        sz  = q_pc.size();
        nv  = (sz > WIDTH) ? WIDTH : sz;
        rdy = (DEPTH - sz) >= WIDTH;
        check("dec_valid", 32'(dec_valid), (nv == 2) ? 32'd3 : 32'(nv));
        check("fetch_ready", 32'(fetch_ready), 32'(rdy));
        for (int i = 0; i < nv; i++) begin
            w = q_instr[i];
            check("lane_pc", dec_uop[i].pc, q_pc[i]);
            check("lane_rd", 32'(dec_uop[i].rd), 32'(w[11:7]));
        end
        @(posedge clk);
        if (fl) begin
            q_pc.delete();
            q_instr.delete();
        end else begin
            if (dr) begin
                for (int i = 0; i < nv; i++) begin
                    void'(q_pc.pop_front());
                    void'(q_instr.pop_front());
                end
            end
            if (fv && rdy) begin
                q_instr.push_back(w0);
                q_pc.push_back(pc);
                if (cnt > 1) begin
                    q_instr.push_back(w1);
                    q_pc.push_back(pc + 32'd4);
                end
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          id;
        logic [31:0] npc;
        rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_count = '0;
        fetch_instr = '0; fetch_pc = '0; dec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        rst = 1'b0;

        // Two ADDIs in one packet, visible the following cycle.
        cycle(1, 2, ADDI5, ADDI7, 32'h100, 0, 0);
        check("addi_valid", 32'(dec_valid), 32'd3);
        check("addi_pc0", dec_uop[0].pc, 32'h100);
        check("addi_pc1", dec_uop[1].pc, 32'h104);
        check("addi_legal0", 32'(dec_uop[0].ctrl.legal), 32'd1);
        check("addi_legal1", 32'(dec_uop[1].ctrl.legal), 32'd1);
        check("addi_uopc", 32'(dec_uop[0].ctrl.uopc), 32'(UOP_ADD));
        check("addi_imm0", dec_uop[0].packed_imm, 32'd5);
        check("addi_imm1", dec_uop[1].packed_imm, 32'd7);
        check("addi_shadowed", 32'(dec_uop[0].shadowed), 32'd0);
        cycle(0, 0, 0, 0, 0, 1, 0);

        // Fill to occupancy 7, offer a packet while not ready, then stream through pointer wrap.
        id  = 1;
        npc = 32'h1000;
        for (int k = 0; k < 3; k++) begin
            cycle(1, 2, mk(id), mk(id + 1), npc, 0, 0);
            id  += 2;
            npc += 32'd8;
        end
        cycle(1, 1, mk(id), 0, npc, 0, 0);
        id  += 1;
        npc += 32'd4;
        check("full_ready", 32'(fetch_ready), 32'd0);
        cycle(1, 2, mk(30), mk(31), 32'hDEAD_0000, 1, 0);
        check("ready_after_pop", 32'(fetch_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cycle(1, 2, mk(id), mk(id + 1), npc, 1, 0);
            id  += 2;
            npc += 32'd8;
        end
        repeat (4) cycle(0, 0, 0, 0, 0, 1, 0);

        // Short forward BEQ (+12) shadows the next two ALU ops, one popped per cycle.
        cycle(1, 1, BEQ12, 0, 32'h200, 1, 0);
        check("beq_shadowed", 32'(dec_uop[0].shadowed), 32'd0);
        check("beq_sfo", 32'(dec_uop[0].sfo_cancel), 32'd0);
        cycle(1, 1, ADD, 0, 32'h204, 1, 0);
        check("add1_shadowed", 32'(dec_uop[0].shadowed), 32'(SFO_ON));
        cycle(1, 1, XOR, 0, 32'h208, 1, 0);
        check("xor_shadowed", 32'(dec_uop[0].shadowed), 32'(SFO_ON));
        cycle(1, 1, ADD, 0, 32'h20C, 1, 0);
        check("add2_shadowed", 32'(dec_uop[0].shadowed), 32'd0);
        cycle(0, 0, 0, 0, 0, 1, 0);
`ifdef DECODE_SFO_EN
        check("shadow_cnt_zero", 32'(dut.shadow_cnt_q), 32'd0);
`endif

        // BNE (+16) then LW in the same packet: the load cancels the shadow.
        cycle(1, 2, BNE16, LW, 32'h300, 0, 0);
        check("bne_legal", 32'(dec_uop[0].ctrl.legal), 32'd1);
        check("lw_uopc", 32'(dec_uop[1].ctrl.uopc), 32'(UOP_LD));
        check("lw_sfo", 32'(dec_uop[1].sfo_cancel), 32'(SFO_ON));
        check("lw_shadowed", 32'(dec_uop[1].shadowed), 32'd0);
        cycle(1, 2, ADD, XOR, 32'h308, 1, 0);
        check("post_add_shadowed", 32'(dec_uop[0].shadowed), 32'd0);
        check("post_xor_shadowed", 32'(dec_uop[1].shadowed), 32'd0);
        check("post_sfo", 32'(dec_uop[0].sfo_cancel), 32'd0);
        cycle(0, 0, 0, 0, 0, 1, 0);

        // Flush with occupancy 4 and a simultaneous push drops everything.
        cycle(1, 2, mk(1), mk(2), 32'h400, 0, 0);
        cycle(1, 2, mk(3), mk(4), 32'h408, 0, 0);
        cycle(1, 2, mk(5), mk(6), 32'h410, 0, 1);
        check("flush_valid", 32'(dec_valid), 32'd0);
        check("flush_ready", 32'(fetch_ready), 32'd1);
        cycle(1, 2, mk(7), mk(8), 32'h500, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);

        // Illegal word passes through; async reset mid-stream clears valid at once.
        cycle(1, 2, 32'hFFFF_FFFF, ADDI5, 32'h600, 0, 0);
        check("ill_valid", 32'(dec_valid), 32'd3);
        check("ill_legal0", 32'(dec_uop[0].ctrl.legal), 32'd0);
        check("ill_legal1", 32'(dec_uop[1].ctrl.legal), 32'd1);
        check("ill_imm1", dec_uop[1].packed_imm, 32'd5);
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(dec_valid), 32'd0);
        check("arst_ready", 32'(fetch_ready), 32'd1);
        q_pc.delete();
        q_instr.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(0, 0, 0, 0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
